// File: rtl/clk_div_prog_if.sv
// Board-side control/status bundle for clk_div_prog: switch/button requests in,
// divider count, CPU clock, tick strobe and active mode out.
interface clk_div_prog_if #(
    parameter int CNT_W = 32
);
    logic [1:0]       mode;
    logic [4:0]       tap_sel;
    logic             step;
    logic [CNT_W-1:0] clkdiv;
    logic             Clk_CPU;
    logic             cpu_tick;
    logic [1:0]       mode_ack;

    modport master (
        output mode, tap_sel, step,
        input  clkdiv, Clk_CPU, cpu_tick, mode_ack
    );
    modport slave (
        input  mode, tap_sel, step,
        output clkdiv, Clk_CPU, cpu_tick, mode_ack
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable CPU clock generator with glitch-free mode/tap switching and single-step.
// Optional step debounce is enabled with `define CLK_DIV_DEBOUNCE_EN.
module clk_div_prog #(
    parameter int CNT_W    = 32,
    parameter int FAST_SEL = 2,
    parameter int SLOW_SEL = 25,
    parameter int STEP_HI  = 4,
    parameter int DB_W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    clk_div_prog_if.slave  bus
);
    // Tap index is kept wide enough to hold CNT_W itself for the clamp compare.
    localparam int TW = ($clog2(CNT_W) >= 5) ? $clog2(CNT_W) + 1 : 6;
    localparam int SW = $clog2(STEP_HI + 1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [1:0] M_FAST = 2'b00;
    localparam logic [1:0] M_SLOW = 2'b01;
    localparam logic [1:0] M_TAP  = 2'b10;
    localparam logic [1:0] M_STEP = 2'b11;

    logic [CNT_W-1:0] r_clkdiv;
    logic [1:0]       r_mode_s1, r_mode_s2;
    logic [4:0]       r_tap_s1, r_tap_s2;
    logic             r_step_s1, r_step_s2;
    logic [6:0]       r_req_d;
    logic [1:0]       r_acc_mode;
    logic [4:0]       r_acc_tap;
    logic [1:0]       r_act_mode;
    logic [TW-1:0]    r_act_tap;
    logic [0:0]       r_state;
    logic             r_clk_cpu;
    logic             r_tick;
    logic             r_step_d;
    logic [SW-1:0]    r_step_cnt;

    logic [6:0]       w_req_sync;
    logic [TW-1:0]    w_tgt_tap;
    logic             w_cfg_diff;
    logic [CNT_W-1:0] w_div_shift;
    logic             w_src;
    logic             w_step_c;
    logic             w_step_rise;
    logic [0:0]       w_state_nx;
    logic             w_clk_nx;
    logic             w_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clkdiv  <= '0;
            r_mode_s1 <= '0;
            r_mode_s2 <= '0;
            r_tap_s1  <= '0;
            r_tap_s2  <= '0;
            r_step_s1 <= 1'b0;
            r_step_s2 <= 1'b0;
        end else begin
            r_clkdiv  <= r_clkdiv + 1'b1;
            r_mode_s1 <= bus.mode;
            r_mode_s2 <= r_mode_s1;
            r_tap_s1  <= bus.tap_sel;
            r_tap_s2  <= r_tap_s1;
            r_step_s1 <= bus.step;
            r_step_s2 <= r_step_s1;
        end
    end

    // A request is accepted once two consecutive synchronised samples agree.
    assign w_req_sync = {r_mode_s2, r_tap_s2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_d    <= '0;
            r_acc_mode <= M_FAST;
            r_acc_tap  <= '0;
        end else begin
            r_req_d <= w_req_sync;
            if (w_req_sync == r_req_d) begin
                r_acc_mode <= w_req_sync[6:5];
                r_acc_tap  <= w_req_sync[4:0];
            end
        end
    end

    always_comb begin
        w_tgt_tap = TW'(FAST_SEL);
        case (r_acc_mode)
            M_SLOW:  w_tgt_tap = TW'(SLOW_SEL);
            M_TAP:   w_tgt_tap = (TW'(r_acc_tap) >= TW'(CNT_W)) ? TW'(CNT_W - 1)
                                                                : TW'(r_acc_tap);
            default: w_tgt_tap = TW'(FAST_SEL);
        endcase
    end

    assign w_cfg_diff  = (r_acc_mode != r_act_mode) || (w_tgt_tap != r_act_tap);
    assign w_div_shift = r_clkdiv >> r_act_tap;
    assign w_src       = (r_act_mode == M_STEP) ? (r_step_cnt != '0) : w_div_shift[0];

`ifdef CLK_DIV_DEBOUNCE_EN
    logic [DB_W-1:0] r_db_cnt;
    logic            r_step_db;

    // Level flips only after 2^DB_W consecutive samples at the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt  <= '0;
            r_step_db <= 1'b0;
        end else if (r_step_s2 != r_step_db) begin
            if (r_db_cnt == '1) begin
                r_step_db <= r_step_s2;
                r_db_cnt  <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_step_c = r_step_db;
`else
    assign w_step_c = r_step_s2;
`endif

    assign w_step_rise = w_step_c & ~r_step_d;

    // Presses during an active step, or outside step mode, are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_d   <= 1'b0;
            r_step_cnt <= '0;
        end else begin
            r_step_d <= w_step_c;
            if (r_step_cnt != '0)
                r_step_cnt <= r_step_cnt - 1'b1;
            else if (w_step_rise && (r_act_mode == M_STEP))
                r_step_cnt <= SW'(STEP_HI);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_clk_nx   = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_clk_nx = w_src;
                if (w_cfg_diff && !r_clk_cpu && !w_src) begin
                    w_load     = 1'b1;
                    w_state_nx = ST_HOLD;
                end
            end
            default: begin
                if (!w_src)
                    w_state_nx = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_clk_cpu  <= 1'b0;
            r_tick     <= 1'b0;
            r_act_mode <= M_FAST;
            r_act_tap  <= TW'(FAST_SEL);
        end else begin
            r_state   <= w_state_nx;
            r_clk_cpu <= w_clk_nx;
            r_tick    <= w_clk_nx & ~r_clk_cpu;
            if (w_load) begin
                r_act_mode <= r_acc_mode;
                r_act_tap  <= w_tgt_tap;
            end
        end
    end

    assign bus.clkdiv   = r_clkdiv;
    assign bus.Clk_CPU  = r_clk_cpu;
    assign bus.cpu_tick = r_tick;
    assign bus.mode_ack = r_act_mode;
endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable CPU clock generator for the board top level: a free-running divider counter plus a registered CPU clock selected from a fast tap, a slow tap, a runtime-chosen tap, or single-step pulses. Mode and tap changes from board switches are synchronised and applied glitch-free, so the CPU never sees a runt pulse. A one-cycle `cpu_tick` strobe marks each CPU clock rising edge for logic running in the `clk` domain.

## Interface
- `CNT_W`, 32: divider counter width.
- `FAST_SEL`, 2: counter bit used in fast mode.
- `SLOW_SEL`, 25: counter bit used in slow mode.
- `STEP_HI`, 4: high time of `Clk_CPU` per single step, in `clk` cycles (≥1).
- `DB_W`, 16: debounce counter width (used only with `CLK_DIV_DEBOUNCE_EN`).

- `clk`  in  1  board clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `mode`  in  2  requested mode, asynchronous: 00 fast, 01 slow, 10 custom tap, 11 single step.
- `tap_sel`  in  5  requested tap for custom mode, asynchronous.
- `step`  in  1  raw step button, asynchronous, active-high.
- `clkdiv`  out  CNT_W  free-running counter.
- `Clk_CPU`  out  1  registered CPU clock.
- `cpu_tick`  out  1  one-cycle pulse in the cycle `Clk_CPU` rises.
- `mode_ack`  out  2  mode currently driving `Clk_CPU`.

## Operation
- `clkdiv` increments by 1 every cycle and wraps from all-ones to 0.
- `mode`, `tap_sel` and `step` each pass through a 2-flop synchroniser. A {mode, tap_sel} request is accepted only after it has been identical for 2 consecutive synchronised cycles.
- Active configuration: {act_mode, act_tap}. `act_tap` is `FAST_SEL` for mode 00, `SLOW_SEL` for 01, and the accepted `tap_sel` for 10, clamped to CNT_W-1 when the request is ≥ CNT_W. `tap_sel` is ignored outside mode 10.
- Source `src`: `clkdiv[act_tap]` in modes 00, 01 and 10. In mode 11 it is the step generator output.
- Step generator: the rising edge of the conditioned `step` loads a counter with `STEP_HI`. `src` stays 1 while the counter is non-zero. Edges arriving while the counter is non-zero are dropped. Edges in modes other than 11 are ignored.
- FSM states:
  - RUN: `Clk_CPU <= src`. If the accepted request differs from the active configuration and both `Clk_CPU` and `src` are 0, load the new configuration and go to HOLD.
  - HOLD: `Clk_CPU` is held at 0. In the first cycle where the new `src` is 0, return to RUN.
- Any `Clk_CPU` high phase therefore completes at full length before a switch, and the first high phase after a switch is a whole one.
- `cpu_tick` = `Clk_CPU` next-value AND NOT current `Clk_CPU`, registered so it is coincident with `Clk_CPU` rising.
- `mode_ack` = act_mode.

## Timing
- Reset values: `clkdiv` 0, `Clk_CPU` 0, `cpu_tick` 0, `mode_ack` 00, act_tap = FAST_SEL, state RUN, step counter 0, synchronisers 0.
- `Clk_CPU` lags the selected counter bit by 1 cycle.
- Request latency: 2 synchroniser cycles + 2 stability cycles, then the wait for `Clk_CPU` and `src` both low, then HOLD until the new `src` is 0.
- Step latency: 2 synchroniser cycles + 1 edge-detect cycle, plus debounce time when enabled. `Clk_CPU` is then high for exactly `STEP_HI` cycles.
- A request change during HOLD is not sampled until RUN is re-entered.
- Reset asserted mid-step or mid-switch returns immediately to the reset values.

## Configuration
- `CLK_DIV_DEBOUNCE_EN` defined: the synchronised `step` must hold a new level for 2^DB_W consecutive cycles before the conditioned level changes. Shorter glitches produce no step.
- `CLK_DIV_DEBOUNCE_EN` undefined: the conditioned step is the synchronised `step`, and the `DB_W` logic is not generated.

## Test plan
Bench parameters: CNT_W=8, FAST_SEL=1, SLOW_SEL=4, STEP_HI=3; debounce disabled unless stated.
- Reset, mode=00 → `clkdiv` counts 0,1,2…255,0; `Clk_CPU` has period 4 and is high 2; `cpu_tick` goes high once per period; `mode_ack`=00.
- Switch mode 00→01 mid-high phase → the current high phase completes; `Clk_CPU` stays low until `clkdiv[4]` goes 0→1; then period 32; no high pulse shorter than 2 or 16 cycles.
- mode=10, tap_sel=3, then tap_sel=20 → period 16, then clamps to tap 7 with period 256; `mode_ack`=10.
- mode=11, one `step` pulse → `Clk_CPU` high exactly 3 cycles, one `cpu_tick`. A second press during the high time → ignored. A press in mode 00 → no extra pulse.
- With `CLK_DIV_DEBOUNCE_EN`, DB_W=4: a 10-cycle `step` glitch gives no pulse; a 20-cycle press gives one 3-cycle pulse.
- Assert `rst` during HOLD and during a step high time → all outputs return to their reset values asynchronously, and the counter restarts from 0.
